// File: rtl/freq_meter_pkg.sv
// ============================================================================
// freq_meter_pkg : shared constants, FSM encoding and clog2 helper
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns / 1ps
`default_nettype none

package freq_meter_pkg;

  localparam int CLK_HZ = 100_000_000;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/freq_meter_sync_edge_det.sv
// ============================================================================
// sync_edge_det : multi-stage synchronizer plus rising-edge pulse
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns / 1ps
`default_nettype none

module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/freq_meter.sv
// ============================================================================
// freq_meter : counts rising edges of an async input over a fixed gate window
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns / 1ps
`default_nettype none

module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = CLK_HZ,
  parameter int CNT_W       = 27,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk100MHz,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             freq_valid,
  output logic             ovf,
  output logic             busy
);

  localparam int            c_GW        = clog2(GATE_CYCLES);
  localparam logic [c_GW-1:0] c_GATE_LAST = c_GW'(GATE_CYCLES - 1);

  logic             w_edge;
  logic             w_at_max;
  logic             w_terminal;
  logic             w_sat_next;
  logic [CNT_W-1:0] w_cnt_next;

  state_t           r_state;
  logic [c_GW-1:0]  r_gate;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [CNT_W-1:0] r_freq_cnt;
  logic             r_sat;
  logic             r_ovf;
  logic             r_valid;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk    (clk100MHz),
    .rst_n  (rst_n),
    .i_async(sig_in),
    .o_edge (w_edge)
  );

  // Next count/sat include this cycle's edge so the terminal cycle can publish it.
  assign w_at_max   = (r_edge_cnt == {CNT_W{1'b1}});
  assign w_cnt_next = (w_edge && !w_at_max) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
  assign w_sat_next = r_sat | (w_edge & w_at_max);
  assign w_terminal = (r_gate == c_GATE_LAST);

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gate     <= '0;
      r_edge_cnt <= '0;
      r_freq_cnt <= '0;
      r_sat      <= 1'b0;
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_gate     <= '0;
          r_edge_cnt <= '0;
          r_sat      <= 1'b0;
          if (en) r_state <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (w_terminal) begin
            r_freq_cnt <= w_cnt_next;
            r_ovf      <= w_sat_next;
            r_valid    <= 1'b1;
            r_gate     <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
            if (!en) r_state <= ST_IDLE;
          end else if (!en) begin
            r_gate     <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_gate     <= r_gate + c_GW'(1);
            r_edge_cnt <= w_cnt_next;
            r_sat      <= w_sat_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign freq_cnt   = r_freq_cnt;
  assign freq_valid = r_valid;
  assign ovf        = r_ovf;
  assign busy       = (r_state == ST_MEASURE);

endmodule

`default_nettype wire
